// File: rtl/sram_req_queue.sv
// -----------------------------------------------------------------------------
// sram_req_queue
//
// Request front-end for the 23K640 SPI SRAM controller. Application requests
// are buffered in a small FIFO; the head request is presented to the controller
// one at a time. Its fields stay stable until the controller reports completion,
// and a completion record is returned to the application for every request.
// A watchdog aborts a request whose completion never arrives. A free-running
// divider produces the controller's i_advance tick.
//
// Handshake semantics (all signals sampled on the rising edge of i_clk):
//   - Application side: a request is taken on every cycle where
//     i_req_valid & o_req_ready. o_req_ready depends only on occupancy,
//     never on i_req_valid.
//   - Controller side: o_valid is high while a request is being offered.
//     i_accept high in such a cycle takes the request. Completion is the
//     rising edge of i_ready seen after acceptance. A level that is already
//     high when acceptance happens does not count.
//   - Completion side: o_cpl_valid is a one-cycle pulse with no back-pressure.
//     o_cpl_err marks a watchdog abort.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_req_valid / o_req_ready / i_req_rd_n_wr / i_req_addr / i_req_data
//                         application request channel
//   o_advance             one-cycle tick every DIV clocks
//   o_valid / i_accept / o_rd_n_wr / o_addr / o_data
//                         request offered to the controller
//   i_ready / i_data      controller completion and read data
//   o_cpl_valid / o_cpl_rd_n_wr / o_cpl_addr / o_cpl_data / o_cpl_err
//                         completion returned to the application
//   o_level               occupancy, including the in-flight head
//   o_state               current FSM state (debug observation)
// -----------------------------------------------------------------------------
module sram_req_queue #(
  parameter int DEPTH   = 4,
  parameter int DIV     = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_rd_n_wr,
  input  logic [15:0]              i_req_addr,
  input  logic [7:0]               i_req_data,
  output logic                     o_advance,
  output logic                     o_valid,
  input  logic                     i_accept,
  output logic                     o_rd_n_wr,
  output logic [15:0]              o_addr,
  output logic [7:0]               o_data,
  input  logic                     i_ready,
  input  logic [7:0]               i_data,
  output logic                     o_cpl_valid,
  output logic                     o_cpl_rd_n_wr,
  output logic [15:0]              o_cpl_addr,
  output logic [7:0]               o_cpl_data,
  output logic                     o_cpl_err,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [1:0]               o_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(DIV);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state;

  // ---------------------------------------------------------------------------
  // Advance divider: counts 0..DIV-1 from reset release, ticks on the last
  // count.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] div_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign o_advance = (div_cnt == DIV_LAST);

  // ---------------------------------------------------------------------------
  // Request FIFO. The head entry stays resident while it is in flight and is
  // popped only in the DONE cycle. As a result, o_level counts the in-flight
  // request, and a full queue keeps refusing pushes even in the cycle the
  // head completes.
  // ---------------------------------------------------------------------------
  logic          mem_rd   [DEPTH];
  logic [15:0]   mem_addr [DEPTH];
  logic [7:0]    mem_data [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          push;
  logic          pop;

  assign o_req_ready = (level != FULL_LEVEL);
  assign push        = i_req_valid & o_req_ready;
  assign pop         = (state == S_DONE);
  assign o_level     = level;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= i_req_rd_n_wr;
      mem_addr[wr_ptr] <= i_req_addr;
      mem_data[wr_ptr] <= i_req_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Completion edge detection. The delayed copy runs every cycle, so a level
  // that went high during ISSUE (or earlier) is already in ready_q on the
  // first WAIT cycle and does not register as a rising edge.
  // ---------------------------------------------------------------------------
  logic ready_q;
  logic ready_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= i_ready;
    end
  end

  assign ready_rise = i_ready & ~ready_q;

  // ---------------------------------------------------------------------------
  // Issue / completion FSM.
  // ---------------------------------------------------------------------------
  logic [TW-1:0] to_cnt;
  logic          fin_ok;
  logic          fin_to;

  // A genuine completion wins over a watchdog expiry in the same cycle,
  // because the read data is valid and the request really finished.
  always_comb begin
    fin_ok = 1'b0;
    fin_to = 1'b0;
    if (state == S_WAIT && ready_rise) begin
      fin_ok = 1'b1;
    end else if ((state == S_ISSUE || state == S_WAIT) && to_cnt == TO_LAST) begin
      fin_to = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      to_cnt        <= '0;
      o_valid       <= 1'b0;
      o_rd_n_wr     <= 1'b0;
      o_addr        <= '0;
      o_data        <= '0;
      o_cpl_valid   <= 1'b0;
      o_cpl_rd_n_wr <= 1'b0;
      o_cpl_addr    <= '0;
      o_cpl_data    <= '0;
      o_cpl_err     <= 1'b0;
    end else begin
      o_cpl_valid <= 1'b0;
      if (fin_ok || fin_to) begin
        // The head fields are still held in o_* here, so they supply the
        // completion record.
        state         <= S_DONE;
        o_valid       <= 1'b0;
        o_cpl_valid   <= 1'b1;
        o_cpl_err     <= fin_to;
        o_cpl_rd_n_wr <= o_rd_n_wr;
        o_cpl_addr    <= o_addr;
        if (fin_to) begin
          o_cpl_data <= '0;
        end else if (o_rd_n_wr) begin
          o_cpl_data <= i_data;
        end else begin
          o_cpl_data <= o_data;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (level != '0) begin
              // Capture the head once. It cannot change until it is popped.
              state     <= S_ISSUE;
              o_valid   <= 1'b1;
              to_cnt    <= '0;
              o_rd_n_wr <= mem_rd[rd_ptr];
              o_addr    <= mem_addr[rd_ptr];
              o_data    <= mem_data[rd_ptr];
            end
          end
          S_ISSUE: begin
            to_cnt <= to_cnt + TW'(1);
            if (i_accept) begin
              state   <= S_WAIT;
              o_valid <= 1'b0;
            end
          end
          S_WAIT: begin
            to_cnt <= to_cnt + TW'(1);
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_sram_req_queue.sv
// -----------------------------------------------------------------------------
// tb_sram_req_queue
//
// Directed bench for sram_req_queue (DEPTH=4, DIV=4, TIMEOUT=64).
//
// Inputs change 1 time unit after the rising edge. Directed checks run at the
// same point. The model/compare process runs on the falling edge.
//
// The model keeps the following state:
//   - req_q: accepted requests that have not yet completed. Its size gives the
//     expected occupancy, and its front gives the expected head fields.
//   - exp_q: completion records, queued in order by the driver at the moment
//     it decides how each request will end.
//   - adv_k: clock count since reset release, used to predict o_advance.
// -----------------------------------------------------------------------------
module tb_sram_req_queue;

  localparam int DEPTH   = 4;
  localparam int DIV     = 4;
  localparam int TIMEOUT = 64;

  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  data;
  } req_t;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_rd_n_wr;
  logic [15:0] i_req_addr;
  logic [7:0]  i_req_data;
  logic        o_advance;
  logic        o_valid;
  logic        i_accept;
  logic        o_rd_n_wr;
  logic [15:0] o_addr;
  logic [7:0]  o_data;
  logic        i_ready;
  logic [7:0]  i_data;
  logic        o_cpl_valid;
  logic        o_cpl_rd_n_wr;
  logic [15:0] o_cpl_addr;
  logic [7:0]  o_cpl_data;
  logic        o_cpl_err;
  logic [2:0]  o_level;
  logic [1:0]  o_state;

  sram_req_queue #(
    .DEPTH   (DEPTH),
    .DIV     (DIV),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_rd_n_wr (i_req_rd_n_wr),
    .i_req_addr    (i_req_addr),
    .i_req_data    (i_req_data),
    .o_advance     (o_advance),
    .o_valid       (o_valid),
    .i_accept      (i_accept),
    .o_rd_n_wr     (o_rd_n_wr),
    .o_addr        (o_addr),
    .o_data        (o_data),
    .i_ready       (i_ready),
    .i_data        (i_data),
    .o_cpl_valid   (o_cpl_valid),
    .o_cpl_rd_n_wr (o_cpl_rd_n_wr),
    .o_cpl_addr    (o_cpl_addr),
    .o_cpl_data    (o_cpl_data),
    .o_cpl_err     (o_cpl_err),
    .o_level       (o_level),
    .o_state       (o_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int unsigned adv_k;
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) adv_k <= 0;
    else          adv_k <= adv_k + 1;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state and check helper
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_err    = 0;
  req_t        req_q[$];
  logic [25:0] exp_q[$];   // {err, rd_n_wr, addr, data}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model
  // ---------------------------------------------------------------------------
  logic        m_accept;
  logic [25:0] m_exp;
  req_t        m_new;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      chk("mon_rst_ready", o_req_ready, 1);
      chk("mon_rst_level", o_level, 0);
      chk("mon_rst_valid", o_valid, 0);
      chk("mon_rst_cpl", o_cpl_valid, 0);
      chk("mon_rst_adv", o_advance, 0);
      req_q.delete();
      exp_q.delete();
    end else begin
      // Acceptance is decided on the occupancy before any same-cycle pop.
      m_accept = i_req_valid && (req_q.size() != DEPTH);
      chk("mon_advance", o_advance, (adv_k % DIV) == (DIV - 1));
      chk("mon_level", o_level, req_q.size());
      chk("mon_req_ready", o_req_ready, req_q.size() != DEPTH);
      if (o_valid) begin
        if (req_q.size() == 0) chk("mon_valid_when_empty", o_valid, 0);
        else chk("mon_head_fields", {o_rd_n_wr, o_addr, o_data}, req_q[0]);
      end
      if (o_cpl_valid) begin
        if (exp_q.size() == 0) begin
          chk("mon_cpl_unexpected", o_cpl_valid, 0);
        end else begin
          m_exp = exp_q.pop_front();
          chk("mon_cpl_record", {o_cpl_err, o_cpl_rd_n_wr, o_cpl_addr, o_cpl_data}, m_exp);
        end
        if (req_q.size() > 0) req_q.delete(0);
      end
      if (m_accept) begin
        m_new.rd   = i_req_rd_n_wr;
        m_new.addr = i_req_addr;
        m_new.data = i_req_data;
        req_q.push_back(m_new);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_req(input logic rd, input logic [15:0] a, input logic [7:0] d);
    i_req_valid   = 1'b1;
    i_req_rd_n_wr = rd;
    i_req_addr    = a;
    i_req_data    = d;
  endtask

  task automatic idle_req();
    i_req_valid = 1'b0;
  endtask

  task automatic push_one(input logic rd, input logic [15:0] a, input logic [7:0] d);
    tick();
    drive_req(rd, a, d);
    tick();
    idle_req();
  endtask

  // Waits for the head to be offered (i_accept held high), then produces a
  // clean rising edge on i_ready inside WAIT and records the expected
  // completion.
  task automatic serve(input logic [7:0] rdata);
    int n;
    n = 0;
    while (!o_valid && n < 200) begin tick(); n++; end
    chk("serve_issue_seen", o_valid, 1);
    tick();
    tick();
    if (req_q.size() > 0)
      exp_q.push_back({1'b0, req_q[0].rd, req_q[0].addr, req_q[0].rd ? rdata : req_q[0].data});
    i_data  = rdata;
    i_ready = 1'b1;
    tick();
    n = 0;
    while (!o_cpl_valid && n < 200) begin tick(); n++; end
    chk("serve_cpl_seen", o_cpl_valid, 1);
    tick();
    i_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int adv_cnt;
  int first_adv;
  int cpl_cnt;
  int n;

  initial begin
    i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_rd_n_wr = 1'b0; i_req_addr = '0;
    i_req_data = '0; i_accept = 1'b0; i_ready = 1'b0; i_data = '0;

    // 1. Reset values, then 20 idle cycles of divider activity.
    tick(); tick();
    chk("rst_req_ready", o_req_ready, 1);
    chk("rst_level", o_level, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_advance", o_advance, 0);
    chk("rst_cpl_fields", {o_cpl_valid, o_cpl_err, o_cpl_rd_n_wr, o_cpl_addr, o_cpl_data}, 0);
    i_rst_n = 1'b1;
    adv_cnt = 0; first_adv = -1;
    for (int c = 0; c < 20; c++) begin
      if (o_advance) begin
        adv_cnt++;
        if (first_adv < 0) first_adv = c;
      end
      tick();
    end
    chk("idle_adv_count", adv_cnt, 5);
    chk("idle_adv_first", first_adv, 3);
    chk("idle_valid", o_valid, 0);
    chk("idle_level", o_level, 0);

    // 2. Single write, accepted at cycle 5, completion edge at cycle 40.
    exp_q.push_back({1'b0, 1'b0, 16'h1234, 8'hA5});
    tick();
    drive_req(1'b0, 16'h1234, 8'hA5);
    chk("wr_ready_before", o_req_ready, 1);
    tick();
    idle_req();
    chk("wr_latency_c1", o_valid, 0);
    chk("wr_level_c1", o_level, 1);
    for (int c = 2; c <= 41; c++) begin
      tick();
      if (c == 5) i_accept = 1'b1;
      if (c == 40) begin i_data = 8'h77; i_ready = 1'b1; end
      if (c == 2) chk("wr_issue_c2", o_valid, 1);
      if (c == 6) chk("wr_wait_c6", o_valid, 0);
      if (c == 40) chk("wr_no_cpl_c40", o_cpl_valid, 0);
      chk("wr_addr_stable", o_addr, 16'h1234);
      chk("wr_data_stable", o_data, 8'hA5);
    end
    chk("wr_cpl_valid", o_cpl_valid, 1);
    chk("wr_cpl_addr", o_cpl_addr, 16'h1234);
    chk("wr_cpl_data", o_cpl_data, 8'hA5);
    chk("wr_cpl_err", o_cpl_err, 0);
    tick();
    i_ready = 1'b0;
    chk("wr_cpl_pulse", o_cpl_valid, 0);
    chk("wr_level_after", o_level, 0);
    chk("wr_cpl_hold", o_cpl_addr, 16'h1234);

    // 3. Single read, i_ready held high for 8 cycles.
    tick();
    drive_req(1'b1, 16'h00FF, 8'h00);
    tick();
    idle_req();
    tick();
    chk("rd_issue", o_valid, 1);
    tick();
    tick();
    exp_q.push_back({1'b0, 1'b1, 16'h00FF, 8'h3C});
    i_data = 8'h3C; i_ready = 1'b1;
    cpl_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 8) i_ready = 1'b0;
      tick();
      if (o_cpl_valid) begin
        cpl_cnt++;
        chk("rd_cpl_data", o_cpl_data, 8'h3C);
        chk("rd_cpl_type", o_cpl_rd_n_wr, 1);
      end
    end
    chk("rd_single_cpl", cpl_cnt, 1);

    // 4/5. Five back-to-back pushes; the fifth waits for the first pop and is
    // refused in the pop cycle itself.
    tick(); drive_req(1'b0, 16'h1000, 8'h11);
    tick(); drive_req(1'b1, 16'h2000, 8'h00);
    tick(); drive_req(1'b0, 16'h3000, 8'h33);
    tick(); drive_req(1'b1, 16'h4000, 8'h00);
    tick(); drive_req(1'b0, 16'h5000, 8'h55);
    chk("full_level", o_level, 4);
    chk("full_ready", o_req_ready, 0);
    exp_q.push_back({1'b0, 1'b0, 16'h1000, 8'h11});
    tick();
    i_data = 8'hEE; i_ready = 1'b1;
    chk("full_ready_c5", o_req_ready, 0);
    tick();
    chk("full_pop_cpl", o_cpl_valid, 1);
    chk("full_pop_level", o_level, 4);
    chk("full_pop_ready", o_req_ready, 0);
    tick();
    i_ready = 1'b0;
    chk("after_pop_level", o_level, 3);
    chk("after_pop_ready", o_req_ready, 1);
    tick();
    idle_req();
    chk("refill_level", o_level, 4);
    serve(8'hB2);
    serve(8'h00);
    serve(8'hD4);
    serve(8'h00);
    chk("drain_level", o_level, 0);

    // 6. Watchdog: no completion edge, abort 64 cycles after entering ISSUE.
    exp_q.push_back({1'b1, 1'b0, 16'hBEEF, 8'h00});
    tick();
    drive_req(1'b0, 16'hBEEF, 8'h5A);
    tick();
    idle_req();
    tick();
    chk("to_issue", o_valid, 1);
    n = 0;
    while (!o_cpl_valid && n < 200) begin tick(); n++; end
    chk("to_latency", n, 64);
    chk("to_err", o_cpl_err, 1);
    chk("to_data", o_cpl_data, 0);
    push_one(1'b1, 16'h0042, 8'h00);
    serve(8'hC3);

    // 7. Reset during WAIT: immediate reset values, no completion afterwards.
    push_one(1'b0, 16'h0ABC, 8'hEE);
    n = 0;
    while (!o_valid && n < 50) begin tick(); n++; end
    chk("rstw_issue", o_valid, 1);
    tick();
    tick();
    i_ready = 1'b1;
    i_rst_n = 1'b0;
    #1;
    chk("rstw_addr", o_addr, 0);
    chk("rstw_data", o_data, 0);
    chk("rstw_level", o_level, 0);
    chk("rstw_ready", o_req_ready, 1);
    chk("rstw_cpl_fields", {o_cpl_valid, o_cpl_err, o_cpl_rd_n_wr, o_cpl_addr, o_cpl_data}, 0);
    tick();
    tick();
    i_rst_n = 1'b1;
    cpl_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) i_ready = 1'b0;
      tick();
      if (o_cpl_valid) cpl_cnt++;
    end
    chk("rstw_no_cpl", cpl_cnt, 0);
    chk("rstw_level_after", o_level, 0);
    push_one(1'b1, 16'h7777, 8'h00);
    serve(8'h99);

    tick();
    chk("end_exp_empty", exp_q.size(), 0);
    chk("end_level", o_level, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_req_queue.md
Name: sram_req_queue

Overview:
- Request front-end sitting directly upstream of the 23K640 SPI SRAM controller.
- Buffers application read/write requests in a FIFO and generates the controller's i_advance tick.
- Presents one request at a time and holds its fields stable until the controller signals completion.
- Returns one completion per request to the application, with a watchdog for lost completions.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
DIV, 4, i_clk cycles per o_advance pulse; minimum 2.
TIMEOUT, 1024, i_clk cycles allowed from issue to completion before abort; minimum 64.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  application request valid
o_req_ready  out  1  queue can accept (not full)
i_req_rd_n_wr  in  1  1=read, 0=write
i_req_addr  in  16  request address
i_req_data  in  8  write data (ignored for reads)
o_advance  out  1  one-cycle tick to controller i_advance
o_valid  out  1  request valid to controller
i_accept  in  1  controller accepted request (pulse or level)
o_rd_n_wr  out  1  head request type
o_addr  out  16  head request address
o_data  out  8  head request write data
i_ready  in  1  controller completion (may stay high several cycles)
i_data  in  8  controller read data
o_cpl_valid  out  1  one-cycle completion pulse
o_cpl_rd_n_wr  out  1  completed request type
o_cpl_addr  out  16  completed request address
o_cpl_data  out  8  read data (reads) / written data (writes)
o_cpl_err  out  1  completion is a timeout abort (qualifies o_cpl_valid)
o_level  out  $clog2(DEPTH)+1  FIFO occupancy incl. in-flight head

Behaviour:
- Clock and reset: single clock i_clk; asynchronous active-low reset i_rst_n.
- Reset values:
  - All outputs 0, except o_req_ready=1.
  - FIFO empty; FSM in IDLE; divider counter 0.
  - Reset mid-transaction aborts silently; no completion is emitted.
- Divider:
  - Counter 0..DIV-1, free-running from reset release.
  - o_advance=1 for exactly one cycle when the counter equals DIV-1.
- FIFO:
  - Push when i_req_valid & o_req_ready; o_req_ready = (level != DEPTH).
  - Push at full is refused even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
  - The head entry stays in the FIFO until its completion; pop occurs on the completion cycle.
  - Simultaneous push and pop when not full: level unchanged.
- o_rd_n_wr/o_addr/o_data are driven from the head entry and are constant from issue through completion.
- FSM:
  - IDLE: o_valid=0. If level>0, go to ISSUE.
  - ISSUE: o_valid=1. On i_accept=1, go to WAIT.
  - WAIT: o_valid=0. Track i_ready with a one-cycle-delayed copy. On the rising edge of i_ready, go to DONE.
  - DONE (one cycle):
    - o_cpl_valid=1, o_cpl_err=0.
    - o_cpl_rd_n_wr/o_cpl_addr copied from head.
    - o_cpl_data = i_data for reads, head data for writes.
    - Pop the head; go to IDLE.
  - Timeout: a cycle counter, cleared on entering ISSUE, counts in ISSUE and WAIT. On reaching TIMEOUT-1 it forces DONE with o_cpl_err=1 and o_cpl_data=0, and the head is popped.
- i_ready already high on entry to WAIT is not a rising edge; a fresh rising edge is required.
- i_ready edges seen in IDLE or ISSUE are ignored.
- Exactly one completion per accepted request, in request order.
- Completion outputs are registered and hold their last values while o_cpl_valid=0.
- Minimum issue latency: a push into an empty queue gives o_valid=1 two cycles later (IDLE then ISSUE).

Test Plan:
- Reset, then idle 20 cycles -> o_advance pulses every DIV=4 cycles; o_valid=0; o_req_ready=1; o_level=0.
- Single write addr=0x1234 data=0xA5; accept at cycle 5; i_ready rises at cycle 40 -> o_addr=0x1234 and o_data=0xA5 stable cycles 2–40; one o_cpl_valid with cpl_addr=0x1234, cpl_data=0xA5, err=0, level back to 0.
- Single read addr=0x00FF with i_data=0x3C on the i_ready rise; i_ready held high 8 cycles -> exactly one completion, cpl_data=0x3C, cpl_rd_n_wr=1.
- Push 5 requests back-to-back at DEPTH=4 -> 5th refused (o_req_ready=0 while level=4) until the first completion; completions arrive in push order.
- Full queue, push attempted on the same cycle as a completion pop -> push refused; level goes 4→3.
- Controller never asserts i_ready, TIMEOUT=64 -> completion with err=1, cpl_data=0 at 64 cycles after ISSUE entry; next request issues normally.
- Assert i_rst_n=0 during WAIT -> all outputs go to reset values immediately; no completion pulse.
